// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
//   arb_state_e : arbiter FSM states
//   ID_W        : grant index width for the default four-requester build
//   rr_pick     : reference round-robin selection (first requester at or
//                 after last_grant+1, wrapping modulo num)
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    ABORT
  } arb_state_e;

  localparam int unsigned MAX_REQ     = 8;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned ID_W        = $clog2(NUM_REQ_DEF);

  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                         input logic [2:0]         last_grant,
                                         input int unsigned        num);
    logic [2:0] idx;
    logic       found;
    rr_pick = last_grant;
    found   = 1'b0;
    for (int unsigned k = 1; k <= num; k++) begin
      idx = 3'((32'(last_grant) + k) % num);
      if (!found && req_vec[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_grant : index served most recently (lowest priority next)
//   pick       : selected index (valid when any=1)
//   any        : at least one request present
// Requests above last_grant are masked in first; if none remain, the
// unmasked vector is searched from index 0, which gives the wrap-around.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] pick,
  output logic                       any
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] hi;
  logic               found_hi;
  logic               found_lo;
  logic [IW-1:0]      pick_hi;
  logic [IW-1:0]      pick_lo;

  always_comb begin
    hi       = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      hi[i] = req[i] && (i > 32'(last_grant));
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (hi[i] && !found_hi) begin
        pick_hi  = i[IW-1:0];
        found_hi = 1'b1;
      end
      if (req[i] && !found_lo) begin
        pick_lo  = i[IW-1:0];
        found_lo = 1'b1;
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
    any  = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter for the UART TX host port.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/data/last : per-requester byte stream (requester i at
//                         req_data[i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready           : per-requester accept
//   flush               : software abort of the current packet
//   tx_data, tx_wr_en   : write port into the UART TX FIFO
//   tx_full             : TX FIFO full
//   abort_tx            : one-cycle abort pulse to the UART
//   grant_valid/id      : packet in progress / current owner
//   pkt_done, pkt_abort : one-cycle completion / abort pulses
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_wr_en,
  input  logic                          tx_full,
  output logic                          abort_tx,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          pkt_done,
  output logic                          pkt_abort
);

  localparam int unsigned GID_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e             state, state_n;
  logic [GID_W-1:0]       last_grant;
  logic [GID_W-1:0]       pick;
  logic                   any_req;
  logic [CNT_W-1:0]       tcnt;
  logic                   g_valid;
  logic                   g_last;
  logic [DATA_WIDTH-1:0]  g_data;
  logic                   accept;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .pick       (pick),
    .any        (any_req)
  );

  always_comb begin
    g_valid = req_valid[grant_id];
    g_last  = req_last[grant_id];
    g_data  = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    accept  = (state == XFER) && g_valid && !tx_full;
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    tx_wr_en  = 1'b0;
    tx_data   = '0;
    case (state)
      IDLE: begin
        if (any_req) state_n = XFER;
      end
      XFER: begin
        req_ready[grant_id] = !tx_full;
        tx_wr_en            = g_valid && !tx_full;
        tx_data             = g_data;
        // A last beat accepted together with flush still completes normally.
        if (accept && g_last)                  state_n = IDLE;
        else if (flush)                        state_n = ABORT;
        else if (!g_valid && tcnt == TO_LAST)  state_n = ABORT;
      end
      ABORT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign grant_valid = (state == XFER);
  assign abort_tx    = (state == ABORT);
  assign pkt_abort   = (state == ABORT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GID_W'(NUM_REQ - 1);
      tcnt       <= '0;
      pkt_done   <= 1'b0;
    end else begin
      state    <= state_n;
      pkt_done <= accept && g_last;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= pick;
            tcnt     <= '0;
          end
        end
        XFER: begin
          if (accept) begin
            tcnt <= '0;
            if (g_last) last_grant <= grant_id;
          end else if (!g_valid && tcnt != TO_MAX) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ABORT: last_grant <= grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester byte queues feed the DUT,
// expected (owner, byte) pairs are queued as stimulus is loaded and popped
// on every TX FIFO write.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              flush;
  logic [DW-1:0]     tx_data;
  logic              tx_wr_en;
  logic              tx_full;
  logic              abort_tx;
  logic              grant_valid;
  logic [1:0]        grant_id;
  logic              pkt_done;
  logic              pkt_abort;

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .flush       (flush),
    .tx_data     (tx_data),
    .tx_wr_en    (tx_wr_en),
    .tx_full     (tx_full),
    .abort_tx    (abort_tx),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .pkt_done    (pkt_done),
    .pkt_abort   (pkt_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } beat_t;

  beat_t       exp_q[$];
  logic [8:0]  mem [NR][16];
  int unsigned len [NR];
  int unsigned ptr [NR];
  logic [NR-1:0] hold;
  logic [NR-1:0] fire;
  int total, bad;
  int cyc_n, last_wr, prev_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic add_pkt(input int r, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      mem[r][len[r]] = {(k == n - 1), base + 8'(k)};
      len[r]++;
    end
  endtask

  task automatic exp_push(input logic [1:0] id, input logic [7:0] d);
    beat_t b;
    b.id = id;
    b.data = d;
    exp_q.push_back(b);
  endtask

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      if (!hold[r] && ptr[r] < len[r]) begin
        req_valid[r]         = 1'b1;
        req_data[r*DW +: DW] = mem[r][ptr[r]][7:0];
        req_last[r]          = mem[r][ptr[r]][8];
      end else begin
        req_valid[r]         = 1'b0;
        req_data[r*DW +: DW] = '0;
        req_last[r]          = 1'b0;
      end
    end
  endtask

  // One clock: drive, check any FIFO write, clock, retire accepted beats.
  task automatic cyc();
    beat_t e;
    drive();
    #1;
    fire = req_valid & req_ready;
    if (tx_wr_en === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected_write observed=%0h expected=none", tx_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data", tx_data, e.data);
        chk("tx_owner", grant_id, e.id);
      end
      prev_wr = last_wr;
      last_wr = cyc_n;
    end
    @(posedge clk);
    for (int r = 0; r < NR; r++) if (fire[r]) ptr[r]++;
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      cyc();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int k;
    logic saw_abort, saw_ready, saw_wr;
    total = 0; bad = 0; cyc_n = 0; last_wr = 0; prev_wr = 0;
    rst = 1'b1; flush = 1'b0; tx_full = 1'b0; hold = '0;
    req_valid = '0; req_data = '0; req_last = '0;
    for (int r = 0; r < NR; r++) begin len[r] = 0; ptr[r] = 0; end

    // Reset state
    repeat (3) cyc();
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_abort", abort_tx, 0);
    chk("rst_wr_en", tx_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);

    // 1: requesters 1 and 2, 3-byte packets
    add_pkt(1, 3, 8'hA1); add_pkt(2, 3, 8'hB1);
    exp_push(1, 8'hA1); exp_push(1, 8'hA2); exp_push(1, 8'hA3);
    exp_push(2, 8'hB1); exp_push(2, 8'hB2); exp_push(2, 8'hB3);
    rst = 1'b0;
    cyc();
    chk("t1_first_grant", grant_id, 1);
    chk("t1_grant_valid", grant_valid, 1);
    repeat (3) cyc();
    chk("t1_pkt_done", pkt_done, 1);
    chk("t1_gv_drop", grant_valid, 0);
    cyc();
    chk("t1_done_pulse", pkt_done, 0);
    chk("t1_second_grant", grant_id, 2);
    cyc();
    chk("t1_gap", last_wr - prev_wr, 2);
    drain("t1_drain", 10);
    cyc();

    // 2: all four requesters, two 1-byte packets each, from a fresh reset
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int r = 0; r < NR; r++) begin
      add_pkt(r, 1, 8'h10 + 8'(r));
      add_pkt(r, 1, 8'h14 + 8'(r));
    end
    for (int r = 0; r < NR; r++) exp_push(2'(r), 8'h10 + 8'(r));
    for (int r = 0; r < NR; r++) exp_push(2'(r), 8'h14 + 8'(r));
    drain("t2_drain", 40);
    cyc();

    // 3: long backpressure never times out
    add_pkt(3, 2, 8'hC1);
    exp_push(3, 8'hC1); exp_push(3, 8'hC2);
    tx_full = 1'b1;
    cyc();
    chk("t3_grant", grant_id, 3);
    saw_abort = 1'b0; saw_ready = 1'b0; saw_wr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      saw_abort |= abort_tx;
      saw_ready |= |req_ready;
      saw_wr    |= tx_wr_en;
    end
    chk("t3_no_abort", saw_abort, 0);
    chk("t3_no_ready", saw_ready, 0);
    chk("t3_no_write", saw_wr, 0);
    chk("t3_still_granted", grant_valid, 1);
    tx_full = 1'b0;
    drive(); #1;
    chk("t3_release_wr", tx_wr_en, 1);
    cyc(); cyc();
    chk("t3_pkt_done", pkt_done, 1);
    chk("t3_drain", exp_q.size(), 0);

    // 4: timeout after requester 0 stalls mid-packet
    add_pkt(0, 4, 8'hD1); add_pkt(1, 1, 8'hE1);
    exp_push(0, 8'hD1); exp_push(0, 8'hD2); exp_push(1, 8'hE1);
    cyc();
    chk("t4_grant", grant_id, 0);
    cyc(); cyc();
    hold[0] = 1'b1;
    k = 41;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (abort_tx) begin k = i; break; end
    end
    chk("t4_timeout_latency", k, 16);
    chk("t4_pkt_abort", pkt_abort, 1);
    chk("t4_gv_abort", grant_valid, 0);
    drive(); #1;
    chk("t4_ready_abort", req_ready, 0);
    chk("t4_wr_abort", tx_wr_en, 0);
    len[0] = ptr[0]; hold[0] = 1'b0;
    cyc();
    chk("t4_abort_pulse", abort_tx, 0);
    cyc();
    chk("t4_next_grant", grant_id, 1);
    drain("t4_drain", 10);
    cyc();

    // 5: flush on last beat completes; flush on middle beat aborts
    add_pkt(2, 2, 8'hF1);
    exp_push(2, 8'hF1); exp_push(2, 8'hF2);
    cyc(); cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t5_done_on_flush", pkt_done, 1);
    chk("t5_no_abort", abort_tx, 0);
    cyc();
    chk("t5_no_abort_after", abort_tx, 0);
    add_pkt(3, 3, 8'h61);
    exp_push(3, 8'h61); exp_push(3, 8'h62);
    cyc();
    chk("t5_grant", grant_id, 3);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t5_flush_abort", abort_tx, 1);
    chk("t5_flush_pkt_abort", pkt_abort, 1);
    chk("t5_flush_no_done", pkt_done, 0);
    chk("t5_drain", exp_q.size(), 0);
    len[3] = ptr[3];
    cyc();
    chk("t5_abort_pulse", abort_tx, 0);

    // 6: reset mid-packet, then requester 0 wins again
    add_pkt(0, 1, 8'h71); add_pkt(1, 5, 8'h81);
    exp_push(0, 8'h71); exp_push(1, 8'h81); exp_push(1, 8'h82);
    drain("t6_pre_drain", 20);
    rst = 1'b1;
    len[1] = ptr[1];
    cyc();
    chk("t6_rst_gv", grant_valid, 0);
    chk("t6_rst_gid", grant_id, 0);
    chk("t6_rst_abort", abort_tx, 0);
    chk("t6_rst_pkt_abort", pkt_abort, 0);
    chk("t6_rst_done", pkt_done, 0);
    add_pkt(0, 1, 8'h91); add_pkt(1, 1, 8'h92);
    exp_push(0, 8'h91); exp_push(1, 8'h92);
    rst = 1'b0;
    cyc();
    chk("t6_grant_after_rst", grant_id, 0);
    drain("t6_drain", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
